// File: rtl/voice_recv_uncache.sv
// Rebuilds 16-bit mono audio samples from a vsync/href byte stream, buffers them, plays one per sample_req.
// Latency: sample written on the edge of its low byte; a granted sample_req updates the outputs one cycle later.
// Backpressure: none upstream (a full buffer drops the sample and pulses overflow); an empty buffer pulses underflow and re-enters prefill.
module voice_recv_uncache #(
  parameter int HREF_WIDTH = 1024,
  parameter int HREF_NUM   = 128,
  parameter int ADDR_W     = 11,
  parameter int PREFILL    = 1024
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              voice_vsync,
  input  logic              voice_href,
  input  logic [7:0]        voice_data,
  input  logic              sample_req,
  output logic [15:0]       ldata_out,
  output logic [15:0]       rdata_out,
  output logic              sample_valid,
  output logic              play_active,
  output logic [ADDR_W:0]   fill_level,
  output logic              line_err,
  output logic              frame_err,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = 11;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  C_WIDTH   = CNT_W'(HREF_WIDTH);
  localparam logic [CNT_W-1:0]  C_NUM     = CNT_W'(HREF_NUM);
  localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_PREFILL = (ADDR_W+1)'(PREFILL);

  typedef enum logic [1:0] {D_IDLE, D_SYNC, D_WAIT, D_LINE} dec_t;
  typedef enum logic       {P_PREFILL, P_PLAY} play_t;

  dec_t               r_dec, w_dec_nxt;
  play_t              r_play, w_play_nxt;
  logic               r_vsync_d, r_href_d;
  logic [CNT_W-1:0]   r_byte_cnt, r_line_cnt;
  logic               r_phase;
  logic [7:0]         r_hi;
  logic [15:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]    r_fill;
  logic [15:0]        r_ldata;
  logic               r_valid, r_line_err, r_frame_err, r_overflow;

  logic               w_vs_rise, w_href_rise;
  logic               w_take, w_line_end, w_frame_chk, w_clr_lines;
  logic [CNT_W-1:0]   w_line_inc, w_lines_now;
  logic               w_wr_req, w_wr_acc, w_rd_acc, w_req_empty;
  logic [15:0]        w_wr_dat;

  assign w_vs_rise   = voice_vsync & ~r_vsync_d;
  assign w_href_rise = voice_href & ~r_href_d;
  assign w_line_inc  = (r_line_cnt == CNT_MAX) ? r_line_cnt : r_line_cnt + CNT_W'(1);
  // the frame check must include a line that is closed on the same cycle
  assign w_lines_now = w_line_end ? w_line_inc : r_line_cnt;
  assign w_wr_req    = w_take & r_phase;
  assign w_wr_dat    = {r_hi, voice_data};
  assign w_wr_acc    = w_wr_req & (r_fill < C_DEPTH);
  assign w_rd_acc    = (r_play == P_PLAY) & sample_req & (r_fill != '0);
  assign w_req_empty = (r_play == P_PLAY) & sample_req & (r_fill == '0);

  // input edge detectors for vsync and href
  always_ff @(posedge sck) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= voice_vsync;
      r_href_d  <= voice_href;
    end
  end

  // decode FSM state register
  always_ff @(posedge sck) begin
    if (rst) r_dec <= D_IDLE;
    else     r_dec <= w_dec_nxt;
  end

  // decode FSM next state; the byte arriving on the href rising edge is taken in WAIT
  always_comb begin
    w_dec_nxt   = r_dec;
    w_take      = 1'b0;
    w_line_end  = 1'b0;
    w_frame_chk = 1'b0;
    w_clr_lines = 1'b0;
    case (r_dec)
      D_IDLE: if (w_vs_rise) w_dec_nxt = D_SYNC;
      D_SYNC: if (!voice_vsync) begin
        w_dec_nxt   = D_WAIT;
        w_clr_lines = 1'b1;
      end
      D_WAIT: begin
        if (w_vs_rise) begin
          w_frame_chk = 1'b1;
          w_dec_nxt   = D_SYNC;
        end else if (w_href_rise) begin
          w_take    = 1'b1;
          w_dec_nxt = D_LINE;
        end
      end
      D_LINE: begin
        if (w_vs_rise) begin
          w_line_end  = 1'b1;
          w_frame_chk = 1'b1;
          w_dec_nxt   = D_SYNC;
        end else if (!voice_href) begin
          w_line_end = 1'b1;
          w_dec_nxt  = D_WAIT;
        end else begin
          w_take = 1'b1;
        end
      end
      default: w_dec_nxt = D_IDLE;
    endcase
  end

  // byte/line counters, high-byte latch and geometry error pulses
  always_ff @(posedge sck) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_line_cnt  <= '0;
      r_phase     <= 1'b0;
      r_hi        <= '0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_take) begin
        if (r_byte_cnt != CNT_MAX) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= voice_data;
      end
      if (w_line_end) begin
        r_byte_cnt <= '0;
        r_phase    <= 1'b0;  // drops a dangling high byte
        r_line_cnt <= w_line_inc;
        r_line_err <= (r_byte_cnt != C_WIDTH);
      end
      if (w_clr_lines) r_line_cnt <= '0;
      if (w_frame_chk) r_frame_err <= (w_lines_now != C_NUM);
    end
  end

  // sample RAM write port
  always_ff @(posedge sck) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= w_wr_dat;
  end

  // circular buffer pointers, occupancy and overflow pulse
  always_ff @(posedge sck) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_wr_req & ~w_wr_acc;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fill <= r_fill + (ADDR_W+1)'(1);
        2'b01:   r_fill <= r_fill - (ADDR_W+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // play FSM state register
  always_ff @(posedge sck) begin
    if (rst) r_play <= P_PREFILL;
    else     r_play <= w_play_nxt;
  end

  // play FSM next state: start once prefilled, fall back on an empty request
  always_comb begin
    w_play_nxt = r_play;
    case (r_play)
      P_PREFILL: if (r_fill >= C_PREFILL) w_play_nxt = P_PLAY;
      P_PLAY:    if (w_req_empty) w_play_nxt = P_PREFILL;
      default:   w_play_nxt = P_PREFILL;
    endcase
  end

  // sample output register: oldest sample on a granted request, zero on underflow
  always_ff @(posedge sck) begin
    if (rst) begin
      r_ldata <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_rd_acc) begin
        r_ldata <= r_mem[r_rd_ptr];
        r_valid <= 1'b1;
      end else if (w_req_empty) begin
        r_ldata <= '0;
        r_valid <= 1'b1;
      end
    end
  end

  assign ldata_out    = r_ldata;
  assign rdata_out    = r_ldata;
  assign sample_valid = r_valid;
  assign play_active  = (r_play == P_PLAY);
  assign fill_level   = r_fill;
  assign line_err     = r_line_err;
  assign frame_err    = r_frame_err;
  assign overflow     = r_overflow;
  assign underflow    = w_req_empty & ~rst;

endmodule

// File: tb/tb_voice_recv_uncache.sv
// Directed bench for voice_recv_uncache using a scaled geometry so every path fits a short run.
// Geometry: 8-byte lines, 4 lines/frame, 16-sample buffer, prefill 8.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_voice_recv_uncache;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0, href = 1'b0, req = 1'b0;
  logic [7:0]    vdata = '0;
  logic [15:0]   ldata, rdata;
  logic          svalid, pactive, lerr, ferr, ovf, udf;
  logic [AW:0]   fill;

  int checks = 0;
  int errors = 0;
  int n_le = 0, n_fe = 0, n_ov = 0, n_uf = 0, n_sv = 0;
  int sv_before;
  logic [7:0]  lb [0:7];
  logic [15:0] exp_a [0:9];
  logic [15:0] exp_b [0:12];

  voice_recv_uncache #(
    .HREF_WIDTH(8), .HREF_NUM(4), .ADDR_W(AW), .PREFILL(8)
  ) dut (
    .sck(clk), .rst(rst), .voice_vsync(vsync), .voice_href(href),
    .voice_data(vdata), .sample_req(req),
    .ldata_out(ldata), .rdata_out(rdata), .sample_valid(svalid),
    .play_active(pactive), .fill_level(fill), .line_err(lerr),
    .frame_err(ferr), .overflow(ovf), .underflow(udf)
  );

  always #5 clk = ~clk;

  // pulse monitor
  always @(posedge clk) begin
    if (lerr)   n_le++;
    if (ferr)   n_fe++;
    if (ovf)    n_ov++;
    if (udf)    n_uf++;
    if (svalid) n_sv++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_lb(input logic [7:0] base);
    for (int k = 0; k < 8; k++) lb[k] = base + 8'(k);
  endtask

  // req_at >= 0 raises sample_req during that byte cycle
  task automatic send_line(input int n, input int req_at);
    for (int k = 0; k < n; k++) begin
      href  = 1'b1;
      vdata = lb[k];
      req   = (k == req_at);
      tick();
    end
    href  = 1'b0;
    vdata = '0;
    req   = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_sync();
    vsync = 1'b1;
    tick(); tick(); tick();
    vsync = 1'b0;
    tick(); tick();
  endtask

  task automatic read_chk(input string tag, input logic [15:0] expv);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk({tag, "_vld"}, svalid, 1);
    chk(tag, ldata, expv);
    chk({tag, "_r"}, rdata, expv);
  endtask

  initial begin
    exp_a = '{16'hA55A, 16'h1234, 16'h5678, 16'h9ABC, 16'h0001,
              16'h0203, 16'h0405, 16'h0607, 16'h1011, 16'h1213};
    exp_b = '{16'h1415, 16'h1617, 16'h2021, 16'h2223, 16'h2425, 16'h2627,
              16'h4041, 16'h4243, 16'h4445, 16'h5051, 16'h5253, 16'h5455, 16'h5657};

    // reset state
    tick(); tick(); tick();
    chk("rst_fill", fill, 0);
    chk("rst_ldata", ldata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", svalid, 0);
    chk("rst_play", pactive, 0);
    chk("rst_lerr", lerr, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    rst = 1'b0;
    tick();

    // href before any vsync is ignored
    set_lb(8'h00);
    send_line(8, -1);
    chk("orphan_fill", fill, 0);
    chk("orphan_lerr", n_le, 0);

    // first line: prefill not reached, requests ignored
    frame_sync();
    lb = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    send_line(8, -1);
    chk("l1_fill", fill, 4);
    chk("l1_play", pactive, 0);
    req = 1'b1; tick(); req = 1'b0; tick();
    chk("pre_req_sv", n_sv, 0);
    chk("pre_req_ldata", ldata, 0);
    chk("pre_req_fill", fill, 4);

    // second line reaches prefill
    set_lb(8'h00);
    send_line(8, -1);
    chk("l2_fill", fill, 8);
    chk("l2_play", pactive, 1);

    // fill to depth, full frame of 4 lines gives no errors
    set_lb(8'h10); send_line(8, -1);
    set_lb(8'h20); send_line(8, -1);
    chk("full_fill", fill, 16);
    chk("full_ovf", n_ov, 0);
    frame_sync();
    chk("frame_ok_fe", n_fe, 0);
    chk("frame_ok_le", n_le, 0);

    // full buffer drops samples
    set_lb(8'h30); send_line(8, -1);
    chk("ovf_fill", fill, 16);
    chk("ovf_cnt", n_ov, 4);

    // playback order; valid is a single-cycle pulse
    read_chk("rd0", exp_a[0]);
    tick();
    chk("rd0_vld_drop", svalid, 0);
    chk("rd0_hold", ldata, 16'hA55A);
    for (int i = 1; i < 10; i++) read_chk($sformatf("rd%0d", i), exp_a[i]);
    chk("rd_fill", fill, 6);

    // short line: one line_err, dangling high byte dropped
    set_lb(8'h40); send_line(7, -1);
    chk("short_le", n_le, 1);
    chk("short_fill", fill, 9);
    set_lb(8'h50); send_line(8, -1);
    chk("after_short_le", n_le, 1);
    chk("after_short_fill", fill, 13);
    frame_sync();
    chk("frame_bad_fe", n_fe, 1);

    // drain, then underflow
    for (int i = 0; i < 13; i++) read_chk($sformatf("dr%0d", i), exp_b[i]);
    chk("drain_fill", fill, 0);
    chk("drain_play", pactive, 1);
    req = 1'b1;
    #1;
    chk("udf_pulse", udf, 1);
    @(posedge clk); #1;
    req = 1'b0;
    chk("udf_vld", svalid, 1);
    chk("udf_ldata", ldata, 0);
    chk("udf_rdata", rdata, 0);
    chk("udf_play", pactive, 0);
    chk("udf_cnt", n_uf, 1);

    // refill restarts playback after another prefill
    set_lb(8'h60); send_line(8, -1);
    chk("refill_fill", fill, 4);
    chk("refill_play", pactive, 0);
    sv_before = n_sv;
    req = 1'b1; tick(); req = 1'b0; tick();
    chk("refill_req_ign", n_sv - sv_before, 0);
    chk("refill_req_fill", fill, 4);
    set_lb(8'h70); send_line(8, -1);
    chk("replay", pactive, 1);
    read_chk("rd_6061", 16'h6061);
    chk("rd_6061_fill", fill, 7);

    // simultaneous read and write keep occupancy
    set_lb(8'h80); send_line(8, 1);
    chk("rw_ldata", ldata, 16'h6263);
    chk("rw_fill", fill, 10);

    // reset in the middle of a line
    frame_sync();
    set_lb(8'h90);
    for (int k = 0; k < 3; k++) begin
      href = 1'b1; vdata = lb[k]; tick();
    end
    rst = 1'b1; href = 1'b0;
    tick(); tick();
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_ldata", ldata, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_valid", svalid, 0);
    chk("mid_rst_play", pactive, 0);
    rst = 1'b0;
    tick();
    set_lb(8'hA0); send_line(8, -1);
    chk("post_rst_fill", fill, 0);
    chk("post_rst_le", n_le, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
